// File: rtl/aes_block_packer.sv
// Word-to-block packer: gathers BLOCK_W/WORD_W bus words into one AES block
// and queues finished blocks in a DEPTH-entry FIFO toward the cipher core.
module aes_block_packer #(
  parameter int WORD_W    = 32,
  parameter int BLOCK_W   = 128,
  parameter int DEPTH     = 4,
  parameter int MSW_FIRST = 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         clear,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [WORD_W-1:0]            in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [BLOCK_W-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         partial
);

  localparam int N  = BLOCK_W / WORD_W;
  localparam int IW = $clog2(N);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [CW-1:0] FULL     = CW'(DEPTH);

  logic [IW-1:0]      word_idx;
  logic [IW-1:0]      slot;
  logic [BLOCK_W-1:0] asm_q;
  logic [BLOCK_W-1:0] merged;
  logic [BLOCK_W-1:0] mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  logic [PW-1:0]      rd_ptr_n;
  logic [CW-1:0]      count_n;
  logic               accept;
  logic               last_word;
  logic               push;
  logic               pop;

  // Full only stalls the final word; earlier words of the next block still land in asm_q.
  always_comb begin
    in_ready  = (word_idx != LAST_IDX) || (count != FULL);
    out_valid = (count != '0);
    partial   = (word_idx != '0);
    accept    = in_valid && in_ready;
    last_word = (word_idx == LAST_IDX);
    push      = accept && last_word && !clear;
    pop       = out_valid && out_ready && !clear;
    rd_ptr_n  = pop ? rd_ptr + PW'(1) : rd_ptr;
    slot      = (MSW_FIRST != 0) ? LAST_IDX - word_idx : word_idx;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    merged  = asm_q;
    count_n = count;
    for (int s = 0; s < N; s++) begin
      if (slot == IW'(s)) merged[s*WORD_W +: WORD_W] = in_data;
    end
    case ({push, pop})
      2'b10:   count_n = count + CW'(1);
      2'b01:   count_n = count - CW'(1);
      default: count_n = count;
    endcase
  end

  // NOTE: block storage has no reset; out_data is a separate reset register, so
  // the unwritten entries are never visible.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= merged;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      word_idx <= '0;
      asm_q    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      out_data <= '0;
    end else if (clear) begin
      word_idx <= '0;
      asm_q    <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      out_data <= '0;
    end else begin
      if (accept) begin
        if (last_word) begin
          word_idx <= '0;
          asm_q    <= '0;
          wr_ptr   <= wr_ptr + PW'(1);
        end else begin
          word_idx <= word_idx + IW'(1);
          asm_q    <= merged;
        end
      end
      rd_ptr <= rd_ptr_n;
      count  <= count_n;
      // Prefetch the next head; bypass when the block being pushed becomes the head.
      if (count_n != '0) begin
        out_data <= (push && (wr_ptr == rd_ptr_n)) ? merged : mem[rd_ptr_n];
      end
    end
  end

endmodule
